// File: rtl/req_debounce16.sv
// Input conditioner for a 16:4 priority encoder. It synchronises and debounces 16 active-low
// request lines and drives registered, glitch-free I[15:0], EI and status flags.
module req_debounce16 #(
  parameter int unsigned TICK_DIV   = 16,  // clocks between debounce samples (>=2)
  parameter int unsigned DB_SAMPLES = 3    // equal samples needed to change a line (>=2)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_n_raw,
  input  logic        en,
  input  logic        freeze,
  output logic [15:0] i_out,
  output logic        ei_n,
  output logic        new_req,
  output logic        all_idle
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TickLast = CntW'(TICK_DIV - 1);

  logic [15:0]                 sync1_q, sync1_d;
  logic [15:0]                 sync_q, sync_d;
  logic [CntW-1:0]             tick_cnt_q, tick_cnt_d;
  logic [15:0][DB_SAMPLES-1:0] hist_q, hist_d;
  logic [15:0]                 i_out_q, i_out_d;
  logic                        ei_n_q, ei_n_d;
  logic                        new_req_q, new_req_d;
  logic                        all_idle_q, all_idle_d;
  logic                        tick;

  // Next-state: synchroniser, sample tick, history shift and stable-value update.
  always_comb begin
    sync1_d    = req_n_raw;
    sync_d     = sync1_q;
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + CntW'(1);
    hist_d     = hist_q;
    i_out_d    = i_out_q;
    if (tick) begin
      for (int b = 0; b < 16; b++) begin
        // Incoming sample is the newest of the DB_SAMPLES entries being judged.
        hist_d[b] = {hist_q[b][DB_SAMPLES-2:0], sync_q[b]};
        if (hist_d[b] == '0) begin
          i_out_d[b] = 1'b0;
        end else if (&hist_d[b]) begin
          i_out_d[b] = 1'b1;
        end
      end
    end
    // Freeze blocks the output update only; the histories above still advance.
    if (freeze) begin
      i_out_d = i_out_q;
    end
    // Only presses (1->0) pulse new_req; releases are silent.
    new_req_d  = |(i_out_q & ~i_out_d);
    all_idle_d = &i_out_d;
    ei_n_d     = ~en;
  end

  // State registers with synchronous reset to the idle (all released) condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '1;
      sync_q     <= '1;
      tick_cnt_q <= '0;
      hist_q     <= '1;
      i_out_q    <= '1;
      ei_n_q     <= 1'b1;
      new_req_q  <= 1'b0;
      all_idle_q <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync_q     <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      hist_q     <= hist_d;
      i_out_q    <= i_out_d;
      ei_n_q     <= ei_n_d;
      new_req_q  <= new_req_d;
      all_idle_q <= all_idle_d;
    end
  end

  assign i_out    = i_out_q;
  assign ei_n     = ei_n_q;
  assign new_req  = new_req_q;
  assign all_idle = all_idle_q;

endmodule

// File: tb/tb_req_debounce16.sv
// Directed self-checking bench for req_debounce16 with TICK_DIV=4, DB_SAMPLES=3.
module tb_req_debounce16;

  logic        clk;
  logic        rst;
  logic [15:0] req_n_raw;
  logic        en;
  logic        freeze;
  logic [15:0] i_out;
  logic        ei_n;
  logic        new_req;
  logic        all_idle;

  int n_checks = 0;
  int n_pass   = 0;

  int first_hit;
  int leave_cnt;
  int pulses;
  int idle_bad;

  req_debounce16 #(
    .TICK_DIV  (4),
    .DB_SAMPLES(3)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_n_raw(req_n_raw),
    .en       (en),
    .freeze   (freeze),
    .i_out    (i_out),
    .ei_n     (ei_n),
    .new_req  (new_req),
    .all_idle (all_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles; reports first cycle (1-based) where i_out==target (-1 if never), cycles
  // after that where i_out left target, new_req pulses, and cycles where all_idle != &i_out.
  task automatic run(input int n, input logic [15:0] target);
    first_hit = -1;
    leave_cnt = 0;
    pulses    = 0;
    idle_bad  = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (new_req === 1'b1) pulses++;
      if (all_idle !== (&i_out)) idle_bad++;
      if (first_hit < 0) begin
        if (i_out === target) first_hit = k;
      end else if (i_out !== target) begin
        leave_cnt++;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_n_raw = 16'h0000;
    en        = 1'b0;
    freeze    = 1'b0;

    // 1: reset state, even with every raw line requesting
    step();
    step();
    check("rst_i_out", 32'(i_out), 32'h0000_FFFF);
    check("rst_ei_n", 32'(ei_n), 32'd1);
    check("rst_new_req", 32'(new_req), 32'd0);
    check("rst_all_idle", 32'(all_idle), 32'd1);

    req_n_raw = 16'hFFFF;
    rst       = 1'b0;
    run(10, 16'hFFFF);
    check("idle_hold", 32'(leave_cnt), 32'd0);

    // 2: clean press of bit 15
    req_n_raw = 16'h7FFF;
    run(20, 16'h7FFF);
    check("press_latency_ok", 32'(first_hit >= 11 && first_hit <= 14), 32'd1);
    check("press_stays", 32'(leave_cnt), 32'd0);
    check("press_pulses", 32'(pulses), 32'd1);
    check("press_all_idle", 32'(all_idle), 32'd0);
    check("press_idle_track", 32'(idle_bad), 32'd0);

    // release before the glitch test
    req_n_raw = 16'hFFFF;
    run(20, 16'hFFFF);
    check("rel1_reached", 32'(first_hit > 0), 32'd1);
    check("rel1_pulses", 32'(pulses), 32'd0);

    // 3: 3-clock glitch on bit 0 never reaches the output
    req_n_raw = 16'hFFFE;
    run(3, 16'hFFFF);
    check("glitch_a_i_out", 32'(leave_cnt), 32'd0);
    check("glitch_a_first", 32'(first_hit), 32'd1);
    req_n_raw = 16'hFFFF;
    run(20, 16'hFFFF);
    check("glitch_b_stays", 32'(leave_cnt), 32'd0);
    check("glitch_b_first", 32'(first_hit), 32'd1);
    check("glitch_pulses", 32'(pulses), 32'd0);

    // 4: freeze holds i_out while histories keep sampling
    freeze    = 1'b1;
    req_n_raw = 16'h3503;
    run(20, 16'hFFFF);
    check("frz_first", 32'(first_hit), 32'd1);
    check("frz_stays", 32'(leave_cnt), 32'd0);
    check("frz_pulses", 32'(pulses), 32'd0);
    freeze = 1'b0;
    run(8, 16'h3503);
    check("unfrz_next_tick", 32'(first_hit >= 1 && first_hit <= 4), 32'd1);
    check("unfrz_stays", 32'(leave_cnt), 32'd0);
    check("unfrz_pulses", 32'(pulses), 32'd1);
    check("unfrz_all_idle", 32'(all_idle), 32'd0);
    check("unfrz_idle_track", 32'(idle_bad), 32'd0);

    // 5: release without pulse, then enable path
    req_n_raw = 16'hFFFF;
    run(20, 16'hFFFF);
    check("rel2_latency_ok", 32'(first_hit >= 11 && first_hit <= 14), 32'd1);
    check("rel2_pulses", 32'(pulses), 32'd0);
    check("rel2_all_idle", 32'(all_idle), 32'd1);
    en = 1'b1;
    #1;
    check("en_before_edge", 32'(ei_n), 32'd1);
    step();
    check("en_after_edge", 32'(ei_n), 32'd0);

    // 6: reset in the middle of a debounce discards partial state
    req_n_raw = 16'hFFFD;
    run(6, 16'hFFFD);
    check("mid_not_yet", 32'(first_hit), 32'hFFFF_FFFF);
    rst = 1'b1;
    step();
    step();
    check("mid_rst_i_out", 32'(i_out), 32'h0000_FFFF);
    check("mid_rst_new_req", 32'(new_req), 32'd0);
    check("mid_rst_all_idle", 32'(all_idle), 32'd1);
    check("mid_rst_ei_n", 32'(ei_n), 32'd1);
    rst = 1'b0;
    run(20, 16'hFFFD);
    check("post_rst_latency_ok", 32'(first_hit >= 11 && first_hit <= 14), 32'd1);
    check("post_rst_pulses", 32'(pulses), 32'd1);
    check("post_rst_stays", 32'(leave_cnt), 32'd0);
    check("post_rst_ei_n", 32'(ei_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
